// File: rtl/spi_xfer_queue_pkg.sv
// Shared types and helpers for the SPI byte-stream front end.
package spi_xfer_queue_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_WAIT_CLR  = 2'd3
    } xfer_state_t;

    // Occupancy counters must represent 0..DEPTH inclusive.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/spi_byte_fifo.sv
// Synchronous show-ahead byte FIFO with occupancy output and synchronous clear.
module spi_byte_fifo
    import spi_xfer_queue_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int DEPTH  = 4,
    localparam int LW     = lvl_w(DEPTH),
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [LW-1:0]     level
);

    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic [AW-1:0]                wr_ptr;
    logic [AW-1:0]                rd_ptr;
    logic                         do_push;
    logic                         do_pop;

    assign do_push = push && (level != LW'(DEPTH));
    assign do_pop  = pop && (level != '0);
    assign head    = mem[rd_ptr];

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/spi_xfer_queue.sv
// Byte-stream front end for SPI_Master: TX bytes become start/data_in transactions,
// returned data_out bytes are queued for the host on done.
module spi_xfer_queue
    import spi_xfer_queue_pkg::*;
#(
    parameter  int DATA_W  = DATA_W_DEF,
    parameter  int DEPTH   = 4,
    parameter  int DONE_TO = 1024,
    localparam int LW      = lvl_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic              flush,
    output logic              spi_start,
    output logic [DATA_W-1:0] spi_data_in,
    input  logic [DATA_W-1:0] spi_data_out,
    input  logic              spi_done,
    output logic              busy,
    output logic [LW-1:0]     tx_level,
    output logic [LW-1:0]     rx_level,
    output logic              err_to
);

    // The ISSUE cycle counts toward the budget, so spi_start stays high exactly
    // DONE_TO cycles on a timeout (DONE_TO must be >= 2).
    localparam int            CW      = $clog2(DONE_TO + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(DONE_TO - 2);

    xfer_state_t       state;
    logic [CW-1:0]     to_cnt;
    logic [DATA_W-1:0] tx_head;
    logic              flush_go;
    logic              can_issue;
    logic              tx_push;
    logic              rx_push;
    logic              rx_pop;

    assign busy      = (state != ST_IDLE);
    assign flush_go  = flush && (state == ST_IDLE);
    assign tx_ready  = (tx_level != LW'(DEPTH)) && !flush;
    assign tx_push   = tx_valid && tx_ready;
    assign rx_valid  = (rx_level != '0);
    assign rx_pop    = rx_valid && rx_ready;
    assign rx_push   = (state == ST_WAIT_DONE) && spi_done;
    // An RX slot is reserved before issue, so a returning byte always fits.
    assign can_issue = (state == ST_IDLE) && (tx_level != '0) &&
                       (rx_level != LW'(DEPTH)) && !spi_done && !flush;

    spi_byte_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .clear     (flush_go),
        .push      (tx_push),
        .push_data (tx_data),
        .pop       (can_issue),
        .head      (tx_head),
        .level     (tx_level)
    );

    spi_byte_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .clear     (flush_go),
        .push      (rx_push),
        .push_data (spi_data_out),
        .pop       (rx_pop),
        .head      (rx_data),
        .level     (rx_level)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            spi_start   <= 1'b0;
            spi_data_in <= '0;
            err_to      <= 1'b0;
            to_cnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (flush)
                        err_to <= 1'b0;
                    if (can_issue) begin
                        spi_data_in <= tx_head;
                        spi_start   <= 1'b1;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    to_cnt <= '0;
                    state  <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (spi_done) begin
                        spi_start <= 1'b0;
                        state     <= ST_WAIT_CLR;
                    end else if (to_cnt == TO_LAST) begin
                        spi_start <= 1'b0;
                        err_to    <= 1'b1;
                        state     <= ST_WAIT_CLR;
                    end else begin
                        to_cnt <= to_cnt + CW'(1);
                    end
                end
                ST_WAIT_CLR: begin
                    if (!spi_done)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_queue.sv
// Directed bench for spi_xfer_queue with a loopback SPI slave model.
module tb_spi_xfer_queue;

    localparam int DATA_W  = 8;
    localparam int DEPTH   = 4;
    localparam int DONE_TO = 16;
    localparam int DLY     = 10;
    localparam int LW      = $clog2(DEPTH) + 1;

    logic              clk;
    logic              reset;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              flush;
    logic              spi_start;
    logic [DATA_W-1:0] spi_data_in;
    logic [DATA_W-1:0] spi_data_out;
    logic              spi_done;
    logic              busy;
    logic [LW-1:0]     tx_level;
    logic [LW-1:0]     rx_level;
    logic              err_to;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          scnt    = 0;
    logic        force_done;
    logic        slave_en;
    logic        start_q = 1'b0;
    logic [7:0]  ret_byte;
    logic [7:0]  issued[$];

    spi_xfer_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DONE_TO(DONE_TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .flush        (flush),
        .spi_start    (spi_start),
        .spi_data_in  (spi_data_in),
        .spi_data_out (spi_data_out),
        .spi_done     (spi_done),
        .busy         (busy),
        .tx_level     (tx_level),
        .rx_level     (rx_level),
        .err_to       (err_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign spi_data_out = ret_byte;

    // Slave: done rises DLY cycles after start, drops once start is low.
    initial spi_done = 1'b0;
    always @(negedge clk) begin
        if (spi_start && !start_q)
            issued.push_back(spi_data_in);
        start_q = spi_start;
        if (spi_start) scnt = scnt + 1;
        else           scnt = 0;
        spi_done = force_done || (slave_en && scnt >= DLY);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 100 && busy; i++) tick();
        chk(tag, busy, 0);
    endtask

    task automatic wait_rx(input int want, input string tag);
        for (int i = 0; i < 300 && rx_level != LW'(want); i++) tick();
        chk(tag, rx_level, want);
    endtask

    task automatic wait_start(input string tag);
        for (int i = 0; i < 20 && !spi_start; i++) tick();
        chk(tag, spi_start, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b0; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0; flush = 1'b0;
        force_done = 1'b0; slave_en = 1'b1; ret_byte = 8'hCC;
        tick(); tick();
        chk("rst_start", spi_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_txl", tx_level, 0);
        chk("rst_rxl", rx_level, 0);
        chk("rst_rxv", rx_valid, 0);
        chk("rst_rxd", rx_data, 0);
        chk("rst_err", err_to, 0);
        chk("rst_sdi", spi_data_in, 0);
        reset = 1'b1;
        tick();
        chk("rst_txrdy", tx_ready, 1);

        // single byte loopback with exact latencies
        push_byte(8'hAA);
        chk("t1_txl", tx_level, 1);
        chk("t1_nostart", spi_start, 0);
        tick();
        chk("t1_start", spi_start, 1);
        chk("t1_sdi", spi_data_in, 8'hAA);
        chk("t1_pop", tx_level, 0);
        repeat (9) tick();
        chk("t1_rxv_early", rx_valid, 0);
        tick();
        chk("t1_rxv", rx_valid, 1);
        chk("t1_rxd", rx_data, 8'hCC);
        chk("t1_rxl", rx_level, 1);
        chk("t1_stop", spi_start, 0);
        rx_ready = 1'b1; tick(); rx_ready = 1'b0;
        chk("t1_rxpop", rx_level, 0);
        wait_idle("t1_idle");

        // stale done blocks issue; TX fills to DEPTH
        force_done = 1'b1;
        tick(); tick();
        for (int i = 1; i <= 4; i++) push_byte(8'(i));
        chk("t2_txl", tx_level, 4);
        chk("t2_rdy", tx_ready, 0);
        chk("t4_nostart", spi_start, 0);
        repeat (3) tick();
        chk("t4_hold", spi_start, 0);
        chk("t4_busy", busy, 0);
        ret_byte   = 8'h5A;
        force_done = 1'b0;
        wait_rx(4, "t3_rx4");
        wait_idle("t3_idle");
        chk("t3_txl", tx_level, 0);
        chk("t2_nissued", issued.size(), 5);
        for (int i = 1; i <= 4; i++)
            if (issued.size() > i) chk($sformatf("t2_ord%0d", i), issued[i], i);

        // RX full holds the fifth byte until the host pops
        push_byte(8'h05);
        repeat (5) tick();
        chk("t3_held", tx_level, 1);
        chk("t3_noiss", busy, 0);
        chk("t3_rxd0", rx_data, 8'h5A);
        rx_ready = 1'b1; tick(); rx_ready = 1'b0;
        wait_rx(4, "t3_refill");
        wait_idle("t3_idle2");
        chk("t3_txl2", tx_level, 0);
        chk("t3_ord5", issued[issued.size()-1], 8'h05);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_drain%0d", i), rx_data, 8'h5A);
            rx_ready = 1'b1; tick(); rx_ready = 1'b0;
        end
        chk("t3_empty", rx_valid, 0);

        // done timeout
        slave_en = 1'b0;
        push_byte(8'h77);
        wait_start("t5_start");
        n = 0;
        while (spi_start && n < 100) begin
            tick();
            n++;
        end
        chk("t5_dur", n, DONE_TO);
        chk("t5_err", err_to, 1);
        chk("t5_rxl", rx_level, 0);
        wait_idle("t5_idle");

        // flush clears TX and err_to, and wins over tx_valid
        force_done = 1'b1;
        tick();
        push_byte(8'h11);
        push_byte(8'h22);
        chk("t5_pre_fl", tx_level, 2);
        tx_data = 8'h33; tx_valid = 1'b1; flush = 1'b1;
        #1;
        chk("t5_flrdy", tx_ready, 0);
        tick();
        flush = 1'b0; tx_valid = 1'b0;
        chk("t5_fl_txl", tx_level, 0);
        chk("t5_fl_err", err_to, 0);
        force_done = 1'b0;
        tick();

        // reset mid-transfer, then a clean transfer
        slave_en = 1'b1;
        ret_byte = 8'hE1;
        push_byte(8'h33);
        push_byte(8'h44);
        chk("t6_pushpop", tx_level, 1);
        repeat (3) tick();
        chk("t6_inflight", spi_start, 1);
        reset = 1'b0;
        #1;
        chk("t6_start0", spi_start, 0);
        chk("t6_txl0", tx_level, 0);
        chk("t6_busy0", busy, 0);
        tick(); tick();
        reset = 1'b1;
        tick();
        push_byte(8'h99);
        wait_rx(1, "t6_rx");
        chk("t6_rxd", rx_data, 8'hE1);
        chk("t6_sdi", issued[issued.size()-1], 8'h99);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
